// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder: measures the high time of a servo pulse and converts
// it back to an angle with a 25-step restoring divider. Out-of-range pulses
// and loss of signal are flagged.
// Optional feature macro: SERVO_DEC_FILTER_EN (glitch filter ahead of edge detect).
module servo_pulse_decoder #(
  parameter int CLK_PER_US    = 50,
  parameter int MIN_US        = 500,
  parameter int MAX_US        = 2500,
  parameter int MAX_ANGLE     = 180,
  parameter int TIMEOUT_TICKS = 1500000,
  parameter int FILTER_TICKS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [7:0]  angle,
  output logic [18:0] width_ticks,
  output logic        angle_valid,
  output logic        range_err,
  output logic        signal_lost,
  output logic        busy
);

  localparam int HW    = 19;
  localparam int NW    = 25;
  localparam int MIN_I = MIN_US * CLK_PER_US;
  localparam int MAX_I = MAX_US * CLK_PER_US;
  localparam int DIV_I = MAX_I - MIN_I;
  localparam int RBW   = $clog2(DIV_I);
  localparam int TW    = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [HW-1:0] MIN_T = HW'(MIN_I);
  localparam logic [HW-1:0] MAX_T = HW'(MAX_I);
  localparam logic [RBW:0]  DIV_R = (RBW + 1)'(DIV_I);
  localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_TICKS);
  localparam logic [NW-1:0] MAXA  = NW'(MAX_ANGLE);

  typedef enum logic [1:0] {
    S_WAIT_LOW = 2'd0,
    S_IDLE     = 2'd1,
    S_HIGH     = 2'd2,
    S_DIVIDE   = 2'd3
  } state_t;

  state_t          state_q;
  logic            sync1_q, sync2_q, prev_q;
  logic            pwm_s, rise_s;
  logic [HW-1:0]   hcnt_q;
  logic [NW-1:0]   num_q;
  logic [RBW-1:0]  rem_q;
  logic [4:0]      icnt_q;
  logic [TW-1:0]   tcnt_q;
  logic [7:0]      angle_q;
  logic [HW-1:0]   width_q;
  logic            angle_valid_q, range_err_q, signal_lost_q, busy_q;

  logic [NW-1:0]   prod_d;
  logic [RBW:0]    rem_sh_s, rem_sub_s;
  logic            ge_s;
  logic [RBW-1:0]  div_rem_d;
  logic [NW-1:0]   div_num_d;

  // Two-flop synchroniser; held high in reset so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef SERVO_DEC_FILTER_EN
  localparam int FW = $clog2(FILTER_TICKS + 1);
  logic          filt_q;
  logic [FW-1:0] fcnt_q;

  // Glitch filter: follow the synchronised level only after it has held for FILTER_TICKS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FW'(FILTER_TICKS - 1)) begin
      filt_q <= sync2_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  assign pwm_s = filt_q;
`else
  assign pwm_s = sync2_q;
`endif

  assign rise_s = pwm_s & ~prev_q;

  // Previous level of pwm_s for edge detection.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= pwm_s;
  end

  // Numerator product and one restoring-division step.
  always_comb begin
    prod_d    = NW'(hcnt_q - MIN_T) * MAXA;
    rem_sh_s  = {rem_q, num_q[NW-1]};
    ge_s      = (rem_sh_s >= DIV_R);
    rem_sub_s = rem_sh_s - DIV_R;
    div_rem_d = rem_sh_s[RBW-1:0];
    if (ge_s) begin
      div_rem_d = rem_sub_s[RBW-1:0];
    end else begin
      div_rem_d = rem_sh_s[RBW-1:0];
    end
    div_num_d = {num_q[NW-2:0], ge_s};
  end

  // Main FSM: measure, range-check, divide; also timeout and sticky signal_lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_LOW;
      hcnt_q        <= '0;
      num_q         <= '0;
      rem_q         <= '0;
      icnt_q        <= 5'd0;
      tcnt_q        <= '0;
      angle_q       <= 8'd0;
      width_q       <= '0;
      angle_valid_q <= 1'b0;
      range_err_q   <= 1'b0;
      signal_lost_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      angle_valid_q <= 1'b0;
      range_err_q   <= 1'b0;
      if (rise_s)              tcnt_q <= '0;
      else if (tcnt_q != TMO)  tcnt_q <= tcnt_q + TW'(1);
      if (tcnt_q == TMO)       signal_lost_q <= 1'b1;
      case (state_q)
        S_WAIT_LOW: begin
          if (!pwm_s) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (rise_s) begin
            hcnt_q  <= 19'd1;
            state_q <= S_HIGH;
            busy_q  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (pwm_s) begin
            if (hcnt_q == MAX_T) begin
              range_err_q <= 1'b1;
              state_q     <= S_WAIT_LOW;
              busy_q      <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q + 19'd1;
            end
          end else if (hcnt_q < MIN_T) begin
            range_err_q <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else begin
            num_q   <= prod_d;
            rem_q   <= '0;
            icnt_q  <= 5'd0;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          num_q  <= div_num_d;
          rem_q  <= div_rem_d;
          icnt_q <= icnt_q + 5'd1;
          if (icnt_q == 5'd24) begin
            angle_q       <= div_num_d[7:0];
            width_q       <= hcnt_q;
            angle_valid_q <= 1'b1;
            signal_lost_q <= 1'b0;
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q <= S_WAIT_LOW;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign angle       = angle_q;
  assign width_ticks = width_q;
  assign angle_valid = angle_valid_q;
  assign range_err   = range_err_q;
  assign signal_lost = signal_lost_q;
  assign busy        = busy_q;

endmodule
